// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters ownership of a shared DW-bit register.
// An ownership ends on request drop or after MAX_HOLD cycles, followed by one release cycle.
module reg_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [IW-1:0]      owner_id,
    output logic               busy,
    output logic [DW-1:0]      q,
    output logic [DW-1:0]      q_bar
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] pick;
    logic          found;
    logic          grant_done;
    logic [IW-1:0] next_ptr;
    int            j;

    // Search starts at ptr and wraps explicitly, so NREQ need not be a power of two.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[IW'(j)]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    assign grant_done = !req[owner_id] || (hold_cnt == HW'(MAX_HOLD - 1));
    assign next_ptr   = (owner_id == IW'(NREQ - 1)) ? '0 : owner_id + IW'(1);
    assign q_bar      = ~q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            busy     <= 1'b0;
            q        <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        gnt      <= NREQ'(1) << pick;
                        owner_id <= pick;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    // The write in the exit cycle still lands.
                    if (we[owner_id]) q <= wdata[owner_id*DW +: DW];
                    hold_cnt <= hold_cnt + HW'(1);
                    if (grant_done) begin
                        state <= RELEASE;
                        gnt   <= '0;
                        ptr   <= next_ptr;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (NREQ=4, DW=8, MAX_HOLD=8) with hand-computed expectations.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  q_bar;

    int checks = 0;
    int errors = 0;

    reg_bank_arbiter #(.NREQ(4), .DW(8), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt), .owner_id(owner_id), .busy(busy), .q(q), .q_bar(q_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] e_gnt;
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        wdata = '0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_owner", 32'(owner_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qbar", 32'(q_bar), 32'hFF);
        do_reset();

        // All requesting: 0,1,2,3,0, each for 8 cycles with a 2-cycle gap.
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            e_gnt = 4'b0001 << (g % 4);
            for (int c = 0; c < 8; c++) begin
                chk("rr_gnt", 32'(gnt), 32'(e_gnt));
                chk("rr_owner", 32'(owner_id), 32'(g % 4));
                tick();
            end
            chk("rr_rel_gnt", 32'(gnt), 32'h0);
            chk("rr_rel_busy", 32'(busy), 32'h1);
            tick();
            chk("rr_idle_gnt", 32'(gnt), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
            if (g == 4) req = 4'b0000;
            tick();
        end
        chk("rr_end_gnt", 32'(gnt), 32'h0);

        do_reset();
        // Single requester 2, one write, then release.
        req = 4'b0100;
        tick();
        chk("one_gnt", 32'(gnt), 32'h4);
        chk("one_owner", 32'(owner_id), 32'h2);
        chk("one_busy", 32'(busy), 32'h1);
        we = 4'b0100; wdata = 32'h00A5_0000;
        tick();
        chk("one_q", 32'(q), 32'hA5);
        chk("one_qbar", 32'(q_bar), 32'h5A);
        we = '0; req = '0;
        tick();
        chk("one_rel_gnt", 32'(gnt), 32'h0);
        chk("one_rel_busy", 32'(busy), 32'h1);
        tick();
        chk("one_idle_busy", 32'(busy), 32'h0);
        chk("one_idle_owner", 32'(owner_id), 32'h2);
        chk("one_idle_q", 32'(q), 32'hA5);

        // ptr=3: requester 0 wins over 2.
        req = 4'b0101;
        tick();
        chk("ptr_gnt0", 32'(gnt), 32'h1);
        req = 4'b0100;
        tick();
        chk("ptr_rel", 32'(gnt), 32'h0);
        tick();
        tick();
        chk("ptr_gnt2", 32'(gnt), 32'h4);
        req = '0;
        tick();
        tick();

        // Owner 1; non-owner write ignored, owner write lands.
        req = 4'b0010;
        tick();
        chk("own_gnt", 32'(gnt), 32'h2);
        we = 4'b0001; wdata = 32'h0000_003C;
        tick();
        chk("nonown_q", 32'(q), 32'hA5);
        we = 4'b0010; wdata = 32'h0000_5A00;
        tick();
        chk("own_q", 32'(q), 32'h5A);

        // Write in the same cycle the owner drops req.
        req = '0; wdata = 32'h0000_7700;
        tick();
        chk("exit_q", 32'(q), 32'h77);
        chk("exit_gnt", 32'(gnt), 32'h0);
        we = '0;
        tick();
        tick();
        chk("exit_idle_busy", 32'(busy), 32'h0);

        // Async reset mid-GRANT with a write pending.
        do_reset();
        req = 4'b1000;
        tick();
        chk("mid_gnt", 32'(gnt), 32'h8);
        we = 4'b1000; wdata = 32'hEE00_0000;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_q", 32'(q), 32'h00);
        chk("mid_rst_qbar", 32'(q_bar), 32'hFF);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        tick();
        chk("mid_hold_q", 32'(q), 32'h00);
        rst_n = 1'b1;
        tick();
        chk("mid_after_q", 32'(q), 32'h00);
        chk("mid_after_gnt", 32'(gnt), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
